// File: rtl/datapath_mc.sv
// datapath_mc: multicycle datapath for an RV32I subset (add, sub, and, or, addi, lw, sw, beq).
// Define DPMC_BNE_EN to also execute bne; without it bne behaves as a nop.
module datapath_mc #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic                          clockDP,
  input  logic                          resetDP,
  input  logic                          run,
  input  logic                          instWe,
  input  logic [$clog2(IMEM_DEPTH)-1:0] instAddr,
  input  logic [31:0]                   instData,
  input  logic [4:0]                    dbgAddr,
  output logic [XLEN-1:0]               dbgData,
  output logic [XLEN-1:0]               pcOut,
  output logic                          busy,
  output logic                          halted
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;
  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d, mdr_q, mdr_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     imem_q [IMEM_DEPTH];
  logic [XLEN-1:0] dmem_q [DMEM_DEPTH];
  logic [XLEN-1:0] rf_q [32];
  logic [6:0]      op, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic            is_add, is_sub, is_and, is_or, is_addi, is_lw, is_sw, is_beq, is_bne;
  logic            is_alu, is_ls, take, rf_we, dm_we;
  logic [XLEN-1:0] b_op, alu, pc4, imm_gen, wb_data;
  logic [IAW-1:0]  i_idx;
  logic [DAW-1:0]  d_idx;
  assign op  = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];
  assign is_add  = op == 7'h33 && f3 == 3'd0 && f7 == 7'h00;
  assign is_sub  = op == 7'h33 && f3 == 3'd0 && f7 == 7'h20;
  assign is_and  = op == 7'h33 && f3 == 3'd7 && f7 == 7'h00;
  assign is_or   = op == 7'h33 && f3 == 3'd6 && f7 == 7'h00;
  assign is_addi = op == 7'h13 && f3 == 3'd0;
  assign is_lw   = op == 7'h03 && f3 == 3'd2;
  assign is_sw   = op == 7'h23 && f3 == 3'd2;
  assign is_beq  = op == 7'h63 && f3 == 3'd0;
`ifdef DPMC_BNE_EN
  assign is_bne  = op == 7'h63 && f3 == 3'd1;
`else
  assign is_bne  = 1'b0;
`endif
  assign is_alu  = is_add || is_sub || is_and || is_or || is_addi;
  assign is_ls   = is_lw || is_sw;
  assign take    = (is_beq && a_q == b_q) || (is_bne && a_q != b_q);
  // The ALU also forms the load/store address A+imm, so no separate ALUOut register is needed.
  assign b_op    = (is_addi || is_ls) ? imm_q : b_q;
  assign alu     = is_sub ? a_q - b_op : is_and ? a_q & b_op : is_or ? a_q | b_op : a_q + b_op;
  assign wb_data = is_lw ? mdr_q : alu;
  assign pc4     = (pc_q + XLEN'(4)) % XLEN'(IMEM_DEPTH * 4);
  assign i_idx   = IAW'((pc_q >> 2) % XLEN'(IMEM_DEPTH));
  assign d_idx   = DAW'((alu >> 2) % XLEN'(DMEM_DEPTH));
  assign imm_gen = op == 7'h23 ? {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]} :
                   op == 7'h63 ? {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0} :
                                 {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
  assign dbgData = dbgAddr == 5'd0 ? '0 : rf_q[dbgAddr];
  assign pcOut   = pc_q;
  assign busy    = state_q != S_IDLE && state_q != S_HALT;
  assign halted  = state_q == S_HALT;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    mdr_d   = mdr_q;
    rf_we   = 1'b0;
    dm_we   = 1'b0;
    case (state_q)
      S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        ir_d    = imem_q[i_idx];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rs1 == 5'd0 ? '0 : rf_q[rs1];
        b_d     = rs2 == 5'd0 ? '0 : rf_q[rs2];
        imm_d   = imm_gen;
        state_d = ir_q == 32'h0 ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_d = is_alu ? S_WB : is_ls ? S_MEM : S_FETCH;
        pc_d    = (is_alu || is_ls) ? pc_q : take ? pc_q + imm_q : pc4;
      end
      S_MEM: begin
        dm_we   = is_sw;
        mdr_d   = is_sw ? mdr_q : dmem_q[d_idx];
        state_d = is_sw ? S_FETCH : S_WB;
        pc_d    = is_sw ? pc4 : pc_q;
      end
      S_WB: begin
        rf_we   = rd != 5'd0;
        state_d = S_FETCH;
        pc_d    = pc4;
      end
      default:  state_d = state_q;
    endcase
  end
  always_ff @(posedge clockDP or posedge resetDP)
    if (resetDP) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      mdr_q   <= '0;
      rf_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      mdr_q   <= mdr_d;
      if (rf_we) rf_q[rd] <= wb_data;
    end
  // Memories are not reset so their contents survive resetDP.
  always_ff @(posedge clockDP) begin
    if (instWe && !busy) imem_q[instAddr] <= instData;
    if (dm_we && !resetDP) dmem_q[d_idx] <= b_q;
  end
endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc: directed programs with hand-computed register, PC and cycle-count expectations.
module tb_datapath_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        inst_we = 1'b0;
  logic [7:0]  inst_addr = '0;
  logic [31:0] inst_data = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data, pc_out;
  logic        busy, halted;
  int          n_tests = 0;
  int          n_fail = 0;

  datapath_mc dut (
    .clockDP(clk), .resetDP(rst), .run(run), .instWe(inst_we), .instAddr(inst_addr),
    .instData(inst_data), .dbgAddr(dbg_addr), .dbgData(dbg_data), .pcOut(pc_out),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rchk(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  function automatic logic [31:0] i_t(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] r_t(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] s_t(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  task automatic wi(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    inst_we = 1'b1; inst_addr = a; inst_data = d;
    @(negedge clk);
    inst_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycles counted from the edge that samples run up to the edge that enters HALT.
  task automatic run_prog(input string tag, input int exp_cyc);
    int n = 0;
    @(negedge clk);
    run = 1'b1;
    do begin
      @(posedge clk);
      #1;
      run = 1'b0;
      n++;
    end while (!halted && n < 500);
    chk(tag, n, exp_cyc);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_pc", pc_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    rchk("rst_x1", 5'd1, 0);
    rst = 1'b0;

    wi(0, i_t(12'd5, 0, 0, 1, 7'h13));
    wi(1, i_t(12'hFFD, 0, 0, 2, 7'h13));
    wi(2, r_t(7'h00, 2, 1, 0, 3));
    wi(3, 32'h0);
    run_prog("cyc_addi_add", 15);
    rchk("x1_5", 5'd1, 32'd5);
    rchk("x2_m3", 5'd2, 32'hFFFF_FFFD);
    rchk("x3_2", 5'd3, 32'd2);
    chk("halt_pc", pc_out, 12);
    @(negedge clk);
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run = 1'b0;
    chk("halt_hold", halted, 1);
    chk("halt_hold_pc", pc_out, 12);

    do_reset();
    wi(0, i_t(12'd1165, 0, 0, 1, 7'h13));
    wi(1, r_t(7'h00, 1, 1, 0, 1));
    wi(2, r_t(7'h00, 1, 1, 0, 1));
    wi(3, s_t(12'd8, 1, 0));
    wi(4, i_t(12'd8, 0, 3'd2, 4, 7'h03));
    wi(5, 32'h0);
    run_prog("cyc_sw_lw", 24);
    rchk("x1_1234", 5'd1, 32'h1234);
    rchk("x4_lw", 5'd4, 32'h1234);
    chk("sw_lw_pc", pc_out, 20);

    do_reset();
    wi(0, i_t(12'h05A, 0, 0, 1, 7'h13));
    wi(1, i_t(12'h00F, 0, 0, 2, 7'h13));
    wi(2, r_t(7'h00, 2, 1, 3'd7, 3));
    wi(3, r_t(7'h00, 2, 1, 3'd6, 4));
    wi(4, r_t(7'h20, 1, 2, 3'd0, 5));
    wi(5, 32'h0);
    run_prog("cyc_logic", 23);
    rchk("and", 5'd3, 32'h0A);
    rchk("or", 5'd4, 32'h5F);
    rchk("sub_wrap", 5'd5, 32'hFFFF_FFB5);

    do_reset();
    wi(0, i_t(12'd1, 0, 0, 1, 7'h13));
    wi(1, b_t(13'd8, 0, 1, 3'd0));
    wi(2, b_t(13'd8, 0, 0, 3'd0));
    wi(3, i_t(12'd1, 0, 0, 6, 7'h13));
    wi(4, i_t(12'd2, 0, 0, 7, 7'h13));
    wi(5, b_t(13'd8, 1, 0, 3'd1));
    wi(6, i_t(12'd3, 0, 0, 8, 7'h13));
    wi(7, 32'h0);
`ifdef DPMC_BNE_EN
    run_prog("cyc_branch", 20);
    rchk("bne_skip_x8", 5'd8, 32'd0);
`else
    run_prog("cyc_branch", 24);
    rchk("bne_nop_x8", 5'd8, 32'd3);
`endif
    rchk("beq_skip_x6", 5'd6, 32'd0);
    rchk("beq_tgt_x7", 5'd7, 32'd2);
    chk("branch_pc", pc_out, 28);

    do_reset();
    wi(0, i_t(12'd7, 0, 0, 0, 7'h13));
    wi(1, i_t(12'd5, 0, 0, 1, 7'h13));
    wi(2, r_t(7'h00, 0, 1, 3'd4, 9));
    wi(3, 32'h0);
    run_prog("cyc_nop", 14);
    rchk("x0_zero", 5'd0, 32'd0);
    rchk("x1_after", 5'd1, 32'd5);
    rchk("xor_nop_x9", 5'd9, 32'd0);

    do_reset();
    wi(0, i_t(12'd4, 0, 0, 1, 7'h13));
    wi(1, i_t(12'd6, 0, 0, 2, 7'h13));
    wi(2, r_t(7'h00, 2, 1, 0, 5));
    wi(3, 32'h0);
    @(negedge clk);
    inst_addr = 8'd3;
    inst_data = i_t(12'd1, 0, 0, 6, 7'h13);
    run = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      run = 1'b0;
      inst_we = (i == 6);
    end
    rst = 1'b1;
    #1;
    rchk("abort_x5", 5'd5, 32'd0);
    chk("abort_pc", pc_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_halted", halted, 0);
    @(negedge clk);
    rst = 1'b0;
    run_prog("cyc_rerun", 15);
    rchk("rerun_x5", 5'd5, 32'd10);
    rchk("busy_we_x6", 5'd6, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/datapath_mc.md
DATAPATH_MC -- requirements
Module: datapath_mc

Interface
REQ-001 Parameter XLEN, default 32, is the register, ALU and data-memory word width; legal values are 32 and 64.
REQ-002 Parameter IMEM_DEPTH, default 256, is the number of 32-bit instruction words.
REQ-003 Parameter DMEM_DEPTH, default 256, is the number of XLEN-bit data words.
REQ-004 clockDP  in  1  is the single clock; all state updates on the rising edge.
REQ-005 resetDP  in  1  is an asynchronous, active-high reset.
REQ-006 run  in  1  starts execution from IDLE.
REQ-007 instWe  in  1  is the instruction-memory write enable.
REQ-008 instAddr  in  $clog2(IMEM_DEPTH)  is the instruction word index.
REQ-009 instData  in  32  is the instruction word to write.
REQ-010 dbgAddr  in  5  is the debug register-file read index.
REQ-011 dbgData  out  XLEN  is the combinational register-file read of dbgAddr; index 0 reads 0.
REQ-012 pcOut  out  XLEN  is the current PC as a byte address.
REQ-013 busy  out  1  is high in every state except IDLE and HALT.
REQ-014 halted  out  1  is high in HALT; it is the successor of endFile.

Function
REQ-015 The datapath is multicycle, one instruction in flight, with FSM states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-016 IDLE -> FETCH when run=1; otherwise the FSM stays in IDLE.
REQ-017 FETCH latches IR <= imem[pc[..:2] mod IMEM_DEPTH], then goes to DECODE.
REQ-018 DECODE latches A=rs1, B=rs2 and the sign-extended immediate; if IR==32'h0 the next state is HALT, else EXEC.
REQ-019 Supported instructions: add, sub, and, or, addi, lw, sw and beq, encoded as RV32I.
REQ-020 EXEC routing: R-type/addi -> WB; lw/sw -> MEM with address A+imm; beq -> FETCH, with pc <= pc+imm if A==B, else pc+4.
REQ-021 MEM routing: sw writes B to dmem[addr>>2 mod DMEM_DEPTH] and goes to FETCH with pc+4; lw reads that word into MDR and goes to WB.
REQ-022 WB writes the result (ALU or MDR) to rd, unless rd==0, then goes to FETCH with pc <= pc+4.
REQ-023 Cycles per instruction: R/addi 4, lw 5, sw 4, beq 3, counted as FETCH to next FETCH.
REQ-024 Any unsupported opcode or funct executes as a nop in 3 cycles (FETCH, DECODE, EXEC), with pc+4.
REQ-025 All arithmetic wraps modulo 2^XLEN; no overflow flag.
REQ-026 Register x0 reads 0 at all times; writes to x0 are discarded.
REQ-027 instWe is honoured only in IDLE or HALT; it is ignored while busy=1.
REQ-028 HALT is held until reset; run is ignored in HALT.
REQ-029 PC increments wrap modulo IMEM_DEPTH*4.

Reset
REQ-030 On resetDP=1, immediately and regardless of clock: state=IDLE, pc=0, IR/A/B/MDR=0, all 32 registers=0, busy=0, halted=0.
REQ-031 Instruction and data memory contents are preserved across reset.
REQ-032 A reset asserted mid-instruction aborts that instruction; a pending register or memory write is not performed.

Configuration
REQ-033 When DPMC_BNE_EN is defined, bne (funct3=001) branches to pc+imm if A!=B, in 3 cycles.
REQ-034 When DPMC_BNE_EN is not defined, bne executes as a nop (REQ-024).

Verification
REQ-035 Program addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; 0 with run=1 -> x3=2, halted=1 after 4+4+4+2 cycles.
REQ-036 Program sw x1,8(x0) with x1=0x1234, then lw x4,8(x0) -> x4=0x1234; sw spans 4 cycles and lw 5.
REQ-037 Program beq x0,x0,+8 at pc=0 -> next FETCH at pc=8 after 3 cycles; instruction at 4 is skipped.
REQ-038 Program addi x0,x0,7 -> dbgData at dbgAddr=0 reads 0.
REQ-039 Reset asserted in WB of add x5,... -> x5 stays 0, pc=0, state IDLE; instruction memory intact; rerun gives the correct result.
REQ-040 bne x0,x1,+8 with x1=1 -> branch taken with DPMC_BNE_EN defined; falls through to pc=4 without it.
